// File: rtl/wdt_pkg.sv
// Shared types and register offsets for the watchdog timer.
package wdt_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COUNT   = 2'd1,
      EXPIRED = 2'd2
   } wdt_state_e;

   localparam logic [11:0] WDT_WDEN_ADDR    = 12'h100;
   localparam logic [11:0] WDT_WDLIVE_ADDR  = 12'h200;
   localparam logic [11:0] WDT_WTOCNT_ADDR  = 12'h300;
   localparam logic [11:0] WDT_WDCNT_ADDR   = 12'h400;
   localparam logic [11:0] WDT_WDSTATE_ADDR = 12'h500;

endpackage

// File: rtl/wdt_ctrl.sv
// Watchdog timer: firmware-programmed threshold, kick register and a
// fixed-length registered timeout pulse on expiry.
module wdt_ctrl
   import wdt_pkg::*;
#(
   parameter int CNT_W     = 32,
   parameter int PULSE_LEN = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        reg_we,
   input  logic [11:0] reg_addr,
   input  logic [31:0] reg_wdata,
   output logic [31:0] reg_rdata,
   output logic        timeout
);

   localparam int HOLD_W = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(PULSE_LEN - 1);

   wdt_state_e        state;
   logic              wden;
   logic [CNT_W-1:0]  wtocnt;
   logic [CNT_W-1:0]  count;
   logic [HOLD_W-1:0] hold;

   logic wden_wr, kick, tocnt_wr, wden_eff;

   always_comb begin
      wden_wr  = reg_we && (reg_addr == WDT_WDEN_ADDR);
      kick     = reg_we && (reg_addr == WDT_WDLIVE_ADDR) && reg_wdata[0];
      tocnt_wr = reg_we && (reg_addr == WDT_WTOCNT_ADDR);
      // enable value in effect after this edge, used when the pulse ends
      wden_eff = wden_wr ? reg_wdata[0] : wden;
   end

   always_comb begin
      reg_rdata = 32'd0;
      case (reg_addr)
         WDT_WDEN_ADDR:    reg_rdata = {31'd0, wden};
         WDT_WTOCNT_ADDR:  reg_rdata = 32'(wtocnt);
         WDT_WDCNT_ADDR:   reg_rdata = 32'(count);
         WDT_WDSTATE_ADDR: reg_rdata = {30'd0, state};
         default:          reg_rdata = 32'd0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         wden    <= 1'b0;
         wtocnt  <= '1;
         count   <= '0;
         hold    <= '0;
         timeout <= 1'b0;
      end else begin
         if (wden_wr)  wden   <= reg_wdata[0];
         if (tocnt_wr) wtocnt <= reg_wdata[CNT_W-1:0];
         case (state)
            IDLE: begin
               count   <= '0;
               hold    <= '0;
               timeout <= 1'b0;
               if (wden_wr && reg_wdata[0]) state <= COUNT;
            end
            COUNT: begin
               if (wden_wr && !reg_wdata[0]) begin
                  state <= IDLE;
                  count <= '0;
               end else if (kick) begin
                  count <= '0;
               end else if (count >= wtocnt) begin
                  // count freezes on expiry, so it can never wrap
                  state   <= EXPIRED;
                  timeout <= 1'b1;
                  hold    <= '0;
               end else begin
                  count <= count + 1'b1;
               end
            end
            EXPIRED: begin
               if (hold == HOLD_LAST) begin
                  timeout <= 1'b0;
                  count   <= '0;
                  hold    <= '0;
                  state   <= wden_eff ? COUNT : IDLE;
               end else begin
                  hold <= hold + 1'b1;
               end
            end
            default: begin
               state   <= IDLE;
               count   <= '0;
               hold    <= '0;
               timeout <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_wdt_ctrl.sv
// Self-checking bench for wdt_ctrl: cycle model plus directed scenarios.
module tb_wdt_ctrl;

   localparam int PULSE_LEN = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        reg_we = 1'b0;
   logic [11:0] reg_addr = 12'h400;
   logic [31:0] reg_wdata = 32'd0;
   logic [31:0] reg_rdata;
   logic        timeout;

   int n_chk = 0;
   int n_fail = 0;
   bit chk_en = 1'b0;

   wdt_ctrl #(.CNT_W(32), .PULSE_LEN(PULSE_LEN)) dut (
      .clk(clk), .rst(rst), .reg_we(reg_we), .reg_addr(reg_addr),
      .reg_wdata(reg_wdata), .reg_rdata(reg_rdata), .timeout(timeout)
   );

   always #5 clk = ~clk;

   // Behavioural model: state 0/1/2, pulse tracked as cycles left high.
   int          m_state = 0;
   bit          m_wden = 1'b0;
   logic [31:0] m_wtocnt = 32'hFFFF_FFFF;
   logic [31:0] m_count = 32'd0;
   int          m_left = 0;

   always @(posedge clk) begin
      bit en_w, to_w, kick, new_en;
      en_w = reg_we && reg_addr == 12'h100;
      to_w = reg_we && reg_addr == 12'h300;
      kick = reg_we && reg_addr == 12'h200 && reg_wdata[0];
      new_en = en_w ? reg_wdata[0] : m_wden;
      if (rst) begin
         m_state = 0; m_wden = 0; m_wtocnt = 32'hFFFF_FFFF; m_count = 0; m_left = 0;
      end else begin
         if (m_state == 0) begin
            if (en_w && reg_wdata[0]) begin m_state = 1; m_count = 0; end
         end else if (m_state == 1) begin
            if (en_w && !reg_wdata[0]) begin m_state = 0; m_count = 0; end
            else if (kick) m_count = 0;
            else if (m_count >= m_wtocnt) begin m_state = 2; m_left = PULSE_LEN; end
            else m_count = m_count + 1;
         end else begin
            m_left = m_left - 1;
            if (m_left == 0) begin m_count = 0; m_state = new_en ? 1 : 0; end
         end
         m_wden = new_en;
         if (to_w) m_wtocnt = reg_wdata;
      end
   end

   function automatic logic [31:0] model_rd(input logic [11:0] a);
      case (a)
         12'h100: return {31'd0, m_wden};
         12'h300: return m_wtocnt;
         12'h400: return m_count;
         12'h500: return 32'(m_state);
         default: return 32'd0;
      endcase
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("timeout", {31'd0, timeout}, {31'd0, m_state == 2});
         chk("rdata", reg_rdata, model_rd(reg_addr));
      end
   end

   logic [11:0] addr_tbl [7] = '{12'h100, 12'h200, 12'h300, 12'h400, 12'h500, 12'h600, 12'h000};
   int rot = 0;

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk); #1;
         reg_addr = addr_tbl[rot % 7];
         rot++;
      end
   endtask

   task automatic wr(input logic [11:0] a, input logic [31:0] d);
      reg_we = 1'b1; reg_addr = a; reg_wdata = d;
      @(posedge clk); #1;
      reg_we = 1'b0;
   endtask

   task automatic peek(input string nm, input logic [11:0] a, input logic [31:0] exp);
      logic [11:0] save;
      save = reg_addr;
      reg_addr = a; #1;
      chk(nm, reg_rdata, exp);
      reg_addr = save;
   endtask

   task automatic chk_to(input string nm, input bit exp);
      chk(nm, {31'd0, timeout}, {31'd0, exp});
   endtask

   initial begin
      bit seen_to;
      int max_cnt;
      @(posedge clk); #1;
      chk_en = 1'b1;
      step(1);
      rst = 1'b0;
      chk_to("reset_timeout", 1'b0);
      peek("reset_state", 12'h500, 32'd0);
      peek("reset_wtocnt", 12'h300, 32'hFFFF_FFFF);

      // basic expiry: threshold 5, enable at edge 0
      wr(12'h300, 32'd5);
      wr(12'h100, 32'd1);
      peek("basic_cnt0", 12'h400, 32'd0);
      peek("basic_state", 12'h500, 32'd1);
      step(5);
      peek("basic_cnt5", 12'h400, 32'd5);
      chk_to("basic_pre", 1'b0);
      step(1);
      chk_to("basic_rise", 1'b1);
      peek("basic_exp", 12'h500, 32'd2);
      step(3);
      chk_to("basic_hold4", 1'b1);
      step(1);
      chk_to("basic_fall", 1'b0);
      peek("basic_restart", 12'h400, 32'd0);
      peek("basic_count_st", 12'h500, 32'd1);

      // periodic kicks keep the watchdog quiet
      wr(12'h100, 32'd0);
      wr(12'h100, 32'd1);
      seen_to = 1'b0; max_cnt = 0;
      for (int i = 0; i < 13; i++) begin
         for (int j = 0; j < 3; j++) begin
            step(1);
            if (timeout) seen_to = 1'b1;
            reg_addr = 12'h400; #1;
            if (int'(reg_rdata) > max_cnt) max_cnt = int'(reg_rdata);
         end
         wr(12'h200, 32'd1);
      end
      chk("kick_no_timeout", {31'd0, seen_to}, 32'd0);
      chk("kick_max_le4", {31'd0, max_cnt <= 4}, 32'd1);

      // kick landing on the compare edge
      wr(12'h100, 32'd0);
      wr(12'h100, 32'd1);
      step(5);
      wr(12'h200, 32'd1);
      chk_to("kick_cmp_to", 1'b0);
      peek("kick_cmp_cnt", 12'h400, 32'd0);
      step(1);
      peek("kick_cmp_cnt1", 12'h400, 32'd1);

      // WDEN=1 while counting does not restart
      step(2);
      wr(12'h100, 32'd1);
      peek("reen_cnt", 12'h400, 32'd4);

      // threshold lowered mid-count
      wr(12'h100, 32'd0);
      wr(12'h300, 32'hFFFF_FFFF);
      wr(12'h100, 32'd1);
      step(20);
      peek("low_cnt20", 12'h400, 32'd20);
      wr(12'h300, 32'd3);
      chk_to("low_pre", 1'b0);
      step(1);
      chk_to("low_rise", 1'b1);

      // disable during pulse: pulse length kept, then idle
      step(1);
      wr(12'h100, 32'd0);
      chk_to("dis_p3", 1'b1);
      peek("dis_wden", 12'h100, 32'd0);
      peek("dis_state", 12'h500, 32'd2);
      step(1);
      chk_to("dis_p4", 1'b1);
      step(1);
      chk_to("dis_end", 1'b0);
      peek("dis_idle", 12'h500, 32'd0);
      peek("dis_cnt", 12'h400, 32'd0);
      wr(12'h200, 32'd1);
      peek("idle_kick_st", 12'h500, 32'd0);
      peek("idle_kick_cnt", 12'h400, 32'd0);

      // zero threshold: expire on first count cycle, one low cycle between pulses
      wr(12'h300, 32'd0);
      wr(12'h100, 32'd1);
      chk_to("zero_pre", 1'b0);
      step(1);
      chk_to("zero_rise", 1'b1);
      step(3);
      chk_to("zero_hold", 1'b1);
      step(1);
      chk_to("zero_gap", 1'b0);
      step(1);
      chk_to("zero_rerise", 1'b1);

      // reset mid-pulse
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      chk_to("rst_to", 1'b0);
      peek("rst_state", 12'h500, 32'd0);
      peek("rst_wden", 12'h100, 32'd0);
      peek("rst_wtocnt", 12'h300, 32'hFFFF_FFFF);
      peek("rst_cnt", 12'h400, 32'd0);

      // read-only / unmapped offsets
      wr(12'h400, 32'd55);
      peek("wdcnt_ro", 12'h400, 32'd0);
      wr(12'h600, 32'hFFFF_FFFF);
      peek("unmapped", 12'h600, 32'd0);
      peek("wdlive_rd", 12'h200, 32'd0);
      step(3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
